// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Produces the PC that the downstream address latch samples every cycle. The next PC is
//   chosen from sequential increment, relative branch, absolute jump, call (push return
//   address) or return (pop), with stall, halt and resume control. All PC arithmetic wraps
//   modulo 2**PC_W.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   stall      in   hold PC, ignore all other controls (except halt_req)
//   halt_req   in   enter HALT, PC held
//   resume     in   leave HALT when halt_req is low
//   branch_en  in   PC <= PC + sext(branch_off)
//   branch_off in   signed branch offset, PC_W bits
//   jump_en    in   PC <= tgt_addr
//   call_en    in   push PC+1, PC <= tgt_addr
//   ret_en     in   PC <= popped return address
//   tgt_addr   in   jump/call target
//   PC         out  current program counter
//   pc_valid   out  PC is fetchable (RUN state)
//   halted     out  FSM is in HALT
//   ras_full   out  return stack holds RAS_DEPTH entries
//   ras_empty  out  return stack holds no entries
//   ras_err    out  sticky overflow/underflow flag, cleared only by reset

module pc_sequencer #(
  parameter int unsigned     PC_W      = 5,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_off,
  input  logic            jump_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic [PC_W-1:0] tgt_addr,
  output logic [PC_W-1:0] PC,
  output logic            pc_valid,
  output logic            halted,
  output logic            ras_full,
  output logic            ras_empty,
  output logic            ras_err
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [CntW-1:0] r_cnt;
  logic            r_err;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_stk_err;
  logic [PtrW-1:0] w_push_idx;
  logic [PtrW-1:0] w_top_idx;

  assign w_full     = (r_cnt == CntW'(RAS_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_push_idx = r_cnt[PtrW-1:0];
  // When full the low pointer bits are zero, so this wraps to the last slot as intended.
  assign w_top_idx  = w_push_idx - PtrW'(1);
  assign w_pc_inc   = r_pc + PC_W'(1);

  // ---------------------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StBoot: w_state_next = StRun;
      StRun: begin
        if (halt_req || w_stk_err) begin
          w_state_next = StHalt;
        end
      end
      StHalt: begin
        if (resume && !halt_req) begin
          w_state_next = StRun;
        end
      end
      default: w_state_next = StBoot;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Next-PC selection and stack requests; only RUN may move the PC or touch the stack.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_stk_err = 1'b0;
    if (r_state == StRun) begin
      if (halt_req || stall) begin
        w_pc_next = r_pc;
      end else if (ret_en) begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_pc_next = r_ras[w_top_idx];
        end else begin
          w_stk_err = 1'b1;
        end
      end else if (call_en) begin
        if (!w_full) begin
          w_push    = 1'b1;
          w_pc_next = tgt_addr;
        end else begin
          w_stk_err = 1'b1;
        end
      end else if (jump_en) begin
        w_pc_next = tgt_addr;
      end else if (branch_en) begin
        // Same-width add is sign-extension modulo 2**PC_W.
        w_pc_next = r_pc + branch_off;
      end else begin
        w_pc_next = w_pc_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // PC and return-address stack registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_push) begin
        r_ras[w_push_idx] <= w_pc_inc;
        r_cnt             <= r_cnt + CntW'(1);
      end else if (w_pop) begin
        r_cnt <= r_cnt - CntW'(1);
      end
      if (w_stk_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs, decoded from registers only
  // ---------------------------------------------------------------------------------------
  always_comb begin
    pc_valid = 1'b0;
    halted   = 1'b0;
    unique case (r_state)
      StRun:   pc_valid = 1'b1;
      StHalt:  halted   = 1'b1;
      default: ;
    endcase
  end

  assign PC        = r_pc;
  assign ras_full  = w_full;
  assign ras_empty = w_empty;
  assign ras_err   = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed, table-driven bench for pc_sequencer (PC_W=5, RESET_PC=0, RAS_DEPTH=4).
//   Each record holds the inputs applied before a rising edge and the outputs expected
//   just after it.

module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       halt_req;
  logic       resume;
  logic       branch_en;
  logic [4:0] branch_off;
  logic       jump_en;
  logic       call_en;
  logic       ret_en;
  logic [4:0] tgt_addr;
  logic [4:0] pc;
  logic       pc_valid;
  logic       halted;
  logic       ras_full;
  logic       ras_empty;
  logic       ras_err;

  int checks;
  int failures;

  typedef struct {
    string      nm;
    logic       rst_n;
    logic       stall;
    logic       halt_req;
    logic       resume;
    logic       branch_en;
    logic [4:0] branch_off;
    logic       jump_en;
    logic       call_en;
    logic       ret_en;
    logic [4:0] tgt;
    logic [4:0] e_pc;
    logic       e_valid;
    logic       e_halted;
    logic       e_full;
    logic       e_empty;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  pc_sequencer #(
    .PC_W      (5),
    .RESET_PC  (5'd0),
    .RAS_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .halt_req   (halt_req),
    .resume     (resume),
    .branch_en  (branch_en),
    .branch_off (branch_off),
    .jump_en    (jump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .tgt_addr   (tgt_addr),
    .PC         (pc),
    .pc_valid   (pc_valid),
    .halted     (halted),
    .ras_full   (ras_full),
    .ras_empty  (ras_empty),
    .ras_err    (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Argument order: name, rst_n, stall, halt_req, resume, branch_en, branch_off, jump_en,
  // call_en, ret_en, tgt | exp pc, pc_valid, halted, ras_full, ras_empty, ras_err
  function automatic vec_t mk(input string nm, input logic rs, input logic st,
                              input logic hr, input logic rm, input logic br,
                              input logic [4:0] off, input logic jp, input logic cl,
                              input logic rt, input logic [4:0] tg, input logic [4:0] ep,
                              input logic ev, input logic eh, input logic ef,
                              input logic ee, input logic er);
    vec_t v;
    v.nm = nm; v.rst_n = rs; v.stall = st; v.halt_req = hr; v.resume = rm;
    v.branch_en = br; v.branch_off = off; v.jump_en = jp; v.call_en = cl; v.ret_en = rt;
    v.tgt = tg; v.e_pc = ep; v.e_valid = ev; v.e_halted = eh; v.e_full = ef;
    v.e_empty = ee; v.e_err = er;
    return v;
  endfunction

  task automatic run(input vec_t v);
    logic [9:0] got;
    logic [9:0] want;
    @(negedge clk);
    rst_n = v.rst_n; stall = v.stall; halt_req = v.halt_req; resume = v.resume;
    branch_en = v.branch_en; branch_off = v.branch_off; jump_en = v.jump_en;
    call_en = v.call_en; ret_en = v.ret_en; tgt_addr = v.tgt;
    @(posedge clk);
    #1;
    got  = {pc, pc_valid, halted, ras_full, ras_empty, ras_err};
    want = {v.e_pc, v.e_valid, v.e_halted, v.e_full, v.e_empty, v.e_err};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got pc=%0d valid=%b halted=%b full=%b empty=%b err=%b; want pc=%0d valid=%b halted=%b full=%b empty=%b err=%b",
               v.nm, pc, pc_valid, halted, ras_full, ras_empty, ras_err,
               v.e_pc, v.e_valid, v.e_halted, v.e_full, v.e_empty, v.e_err);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; stall = 1'b0; halt_req = 1'b0; resume = 1'b0; branch_en = 1'b0;
    branch_off = '0; jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; tgt_addr = '0;

    // Reset and boot
    tbl.push_back(mk("rst_a",      0,0,0,0,0,5'd0,0,0,0,5'd0,   5'd0, 0,0,0,1,0));
    tbl.push_back(mk("rst_b",      0,0,0,0,0,5'd0,0,0,0,5'd0,   5'd0, 0,0,0,1,0));
    tbl.push_back(mk("boot_hold",  1,0,0,0,0,5'd0,1,0,0,5'd9,   5'd0, 1,0,0,1,0));
    tbl.push_back(mk("inc1",       1,0,0,0,0,5'd0,0,0,0,5'd0,   5'd1, 1,0,0,1,0));
    tbl.push_back(mk("inc2",       1,0,0,0,0,5'd0,0,0,0,5'd0,   5'd2, 1,0,0,1,0));
    tbl.push_back(mk("inc3",       1,0,0,0,0,5'd0,0,0,0,5'd0,   5'd3, 1,0,0,1,0));
    // Wrap-around and branches
    tbl.push_back(mk("jmp30",      1,0,0,0,0,5'd0,1,0,0,5'd30,  5'd30,1,0,0,1,0));
    tbl.push_back(mk("inc31",      1,0,0,0,0,5'd0,0,0,0,5'd0,   5'd31,1,0,0,1,0));
    tbl.push_back(mk("wrap0",      1,0,0,0,0,5'd0,0,0,0,5'd0,   5'd0, 1,0,0,1,0));
    tbl.push_back(mk("inc_1",      1,0,0,0,0,5'd0,0,0,0,5'd0,   5'd1, 1,0,0,1,0));
    tbl.push_back(mk("br_m2",      1,0,0,0,1,5'b11110,0,0,0,5'd0, 5'd31,1,0,0,1,0));
    tbl.push_back(mk("br_p3",      1,0,0,0,1,5'd3,0,0,0,5'd0,   5'd2, 1,0,0,1,0));
    tbl.push_back(mk("jmp_over_br",1,0,0,0,1,5'd5,1,0,0,5'd7,   5'd7, 1,0,0,1,0));
    // Stall masks jump/call/ret
    tbl.push_back(mk("stall_jmp1", 1,1,0,0,0,5'd0,1,0,0,5'd20,  5'd7, 1,0,0,1,0));
    tbl.push_back(mk("stall_jmp2", 1,1,0,0,0,5'd0,1,0,0,5'd20,  5'd7, 1,0,0,1,0));
    tbl.push_back(mk("stall_jmp3", 1,1,0,0,0,5'd0,1,0,0,5'd20,  5'd7, 1,0,0,1,0));
    tbl.push_back(mk("jmp20",      1,0,0,0,0,5'd0,1,0,0,5'd20,  5'd20,1,0,0,1,0));
    tbl.push_back(mk("stall_call", 1,1,0,0,0,5'd0,0,1,0,5'd5,   5'd20,1,0,0,1,0));
    tbl.push_back(mk("stall_ret",  1,1,0,0,0,5'd0,0,0,1,5'd0,   5'd20,1,0,0,1,0));
    // Call / return
    tbl.push_back(mk("jmp3",       1,0,0,0,0,5'd0,1,0,0,5'd3,   5'd3, 1,0,0,1,0));
    tbl.push_back(mk("call10",     1,0,0,0,0,5'd0,0,1,0,5'd10,  5'd10,1,0,0,0,0));
    tbl.push_back(mk("inc11",      1,0,0,0,0,5'd0,0,0,0,5'd0,   5'd11,1,0,0,0,0));
    tbl.push_back(mk("call25",     1,0,0,0,0,5'd0,0,1,0,5'd25,  5'd25,1,0,0,0,0));
    tbl.push_back(mk("ret12",      1,0,0,0,0,5'd0,0,0,1,5'd0,   5'd12,1,0,0,0,0));
    tbl.push_back(mk("ret4",       1,0,0,0,0,5'd0,0,0,1,5'd0,   5'd4, 1,0,0,1,0));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Overflow: four nested calls fill the stack (returns 5,9,9,9), fifth one halts.
    for (int i = 0; i < 4; i++) begin
      run(mk("call_nest",  1,0,0,0,0,5'd0,0,1,0,5'd8,  5'd8,1,0,(i==3),0,0));
    end
    run(mk("call_ovf",     1,0,0,0,0,5'd0,0,1,0,5'd8,  5'd8,0,1,1,0,1));
    run(mk("ovf_hold",     1,0,0,0,0,5'd0,0,0,0,5'd0,  5'd8,0,1,1,0,1));
    run(mk("halt_ign_ctl", 1,0,0,0,0,5'd0,1,1,1,5'd3,  5'd8,0,1,1,0,1));
    run(mk("ovf_resume",   1,0,0,1,0,5'd0,0,0,0,5'd0,  5'd8,1,0,1,0,1));
    run(mk("pop9_a",       1,0,0,0,0,5'd0,0,0,1,5'd0,  5'd9,1,0,0,0,1));
    run(mk("pop9_b",       1,0,0,0,0,5'd0,0,0,1,5'd0,  5'd9,1,0,0,0,1));
    run(mk("pop9_c",       1,0,0,0,0,5'd0,0,0,1,5'd0,  5'd9,1,0,0,0,1));
    run(mk("pop5",         1,0,0,0,0,5'd0,0,0,1,5'd0,  5'd5,1,0,0,1,1));

    // Underflow on a freshly reset stack
    run(mk("rst_c",        0,0,0,0,0,5'd0,0,0,0,5'd0,  5'd0,0,0,0,1,0));
    run(mk("boot_c",       1,0,0,0,0,5'd0,0,0,0,5'd0,  5'd0,1,0,0,1,0));
    run(mk("ret_unf",      1,0,0,0,0,5'd0,0,0,1,5'd0,  5'd0,0,1,0,1,1));
    run(mk("unf_hold",     1,0,0,0,0,5'd0,0,0,0,5'd0,  5'd0,0,1,0,1,1));
    run(mk("unf_resume",   1,0,0,1,0,5'd0,0,0,0,5'd0,  5'd0,1,0,0,1,1));
    run(mk("unf_inc",      1,0,0,0,0,5'd0,0,0,0,5'd0,  5'd1,1,0,0,1,1));

    // Halt / resume, then reset while halted
    run(mk("rst_d",        0,0,0,0,0,5'd0,0,0,0,5'd0,  5'd0,0,0,0,1,0));
    run(mk("boot_d",       1,0,0,0,0,5'd0,0,0,0,5'd0,  5'd0,1,0,0,1,0));
    run(mk("call9",        1,0,0,0,0,5'd0,0,1,0,5'd9,  5'd9,1,0,0,0,0));
    run(mk("halt_over_ret",1,0,1,0,0,5'd0,0,0,1,5'd0,  5'd9,0,1,0,0,0));
    for (int i = 0; i < 3; i++) begin
      run(mk("halt_frozen",1,0,0,0,0,5'd0,1,0,0,5'd20, 5'd9,0,1,0,0,0));
    end
    run(mk("resume_w_hr",  1,0,1,1,0,5'd0,0,0,0,5'd0,  5'd9,0,1,0,0,0));
    run(mk("resume",       1,0,0,1,0,5'd0,0,0,0,5'd0,  5'd9,1,0,0,0,0));
    run(mk("post_res10",   1,0,0,0,0,5'd0,0,0,0,5'd0,  5'd10,1,0,0,0,0));
    run(mk("post_res11",   1,0,0,0,0,5'd0,0,0,0,5'd0,  5'd11,1,0,0,0,0));
    run(mk("halt11",       1,0,1,0,0,5'd0,0,0,0,5'd0,  5'd11,0,1,0,0,0));
    run(mk("rst_in_halt",  0,0,1,0,0,5'd0,0,1,0,5'd4,  5'd0,0,0,0,1,0));
    run(mk("boot_e",       1,0,0,0,0,5'd0,0,0,0,5'd0,  5'd0,1,0,0,1,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
